// File: rtl/cube_frame_rx.sv
// Assembles LED-cube frames (HDR0 HDR1, PAYLOAD_LEN payload bytes, checksum) from a
// UART byte stream into the back half of a double-buffered frame RAM.
module cube_frame_rx #(
   parameter logic [7:0]  HDR0        = 8'hA5,
   parameter logic [7:0]  HDR1        = 8'h5A,
   parameter int unsigned PAYLOAD_LEN = 64,
   parameter int unsigned TIMEOUT     = 100000
) (
   input  logic                          clk_100M_i,
   input  logic                          rst_i,
   input  logic                          byte_valid_i,
   input  logic [7:0]                    byte_i,
   output logic                          wr_en_o,
   output logic [$clog2(PAYLOAD_LEN):0]  wr_addr_o,
   output logic [7:0]                    wr_data_o,
   output logic                          front_buf_o,
   output logic                          frame_done_o,
   output logic                          frame_err_o,
   output logic                          busy_o
);

   localparam int unsigned   IW       = $clog2(PAYLOAD_LEN);
   localparam int unsigned   TW       = $clog2(TIMEOUT);
   localparam logic [IW-1:0] IDX_LAST = IW'(PAYLOAD_LEN - 1);
   localparam logic [TW-1:0] T_LAST   = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_HDR,
      S_DATA,
      S_CSUM
   } state_t;

   state_t        state_q,   state_d;
   logic [IW-1:0] index_q,   index_d;
   logic [7:0]    sum_q,     sum_d;
   logic [TW-1:0] timer_q,   timer_d;
   logic          wr_en_q,   wr_en_d;
   logic [IW:0]   wr_addr_q, wr_addr_d;
   logic [7:0]    wr_data_q, wr_data_d;
   logic          front_q,   front_d;
   logic          done_q,    done_d;
   logic          err_q,     err_d;
   logic          busy_q,    busy_d;

   always_ff @(posedge clk_100M_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= S_IDLE;
         index_q   <= '0;
         sum_q     <= '0;
         timer_q   <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         front_q   <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         index_q   <= index_d;
         sum_q     <= sum_d;
         timer_q   <= timer_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         front_q   <= front_d;
         done_q    <= done_d;
         err_q     <= err_d;
         busy_q    <= busy_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      index_d   = index_q;
      sum_d     = sum_q;
      timer_d   = (state_q != S_IDLE) ? timer_q + 1'b1 : '0;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      front_d   = front_q;
      done_d    = 1'b0;
      err_d     = 1'b0;

      // A byte arriving on the expiry cycle takes priority over the timeout.
      if (byte_valid_i) begin
         timer_d = '0;
         case (state_q)
            S_IDLE: begin
               if (byte_i == HDR0) state_d = S_HDR;
            end
            S_HDR: begin
               if (byte_i == HDR1) begin
                  state_d = S_DATA;
                  index_d = '0;
                  sum_d   = '0;
               end else if (byte_i != HDR0) begin
                  state_d = S_IDLE;
               end
            end
            S_DATA: begin
               wr_en_d   = 1'b1;
               wr_data_d = byte_i;
               wr_addr_d = {~front_q, index_q};
               index_d   = index_q + 1'b1;
               sum_d     = sum_q + byte_i;
               if (index_q == IDX_LAST) state_d = S_CSUM;
            end
            S_CSUM: begin
               if (byte_i == sum_q) begin
                  done_d  = 1'b1;
                  front_d = ~front_q;
               end else begin
                  err_d = 1'b1;
               end
               state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end else if (state_q != S_IDLE && timer_q == T_LAST) begin
         state_d = S_IDLE;
         timer_d = '0;
         err_d   = (state_q == S_DATA) || (state_q == S_CSUM);
      end

      busy_d = (state_d != S_IDLE);
   end

   assign wr_en_o      = wr_en_q;
   assign wr_addr_o    = wr_addr_q;
   assign wr_data_o    = wr_data_q;
   assign front_buf_o  = front_q;
   assign frame_done_o = done_q;
   assign frame_err_o  = err_q;
   assign busy_o       = busy_q;

endmodule

// File: tb/tb_cube_frame_rx.sv
// Directed/randomized bench for cube_frame_rx with a frame-level reference model.
module tb_cube_frame_rx;

   localparam int unsigned TMO = 200;
   localparam int unsigned PL  = 64;

   logic       clk = 1'b0;
   logic       rst;
   logic       bv;
   logic [7:0] bt;
   logic       wr_en;
   logic [6:0] wr_addr;
   logic [7:0] wr_data;
   logic       front, done, err, busy;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   cube_frame_rx #(.TIMEOUT(TMO)) dut (
      .clk_100M_i   (clk),
      .rst_i        (rst),
      .byte_valid_i (bv),
      .byte_i       (bt),
      .wr_en_o      (wr_en),
      .wr_addr_o    (wr_addr),
      .wr_data_o    (wr_data),
      .front_buf_o  (front),
      .frame_done_o (done),
      .frame_err_o  (err),
      .busy_o       (busy)
   );

   // Observed RAM writes and pulse counts, sampled away from the clock edge.
   int wq[$];
   int n_done = 0;
   int n_err  = 0;
   always @(negedge clk) begin
      if (wr_en === 1'b1) wq.push_back(int'(wr_addr) * 256 + int'(wr_data));
      if (done === 1'b1) n_done++;
      if (err === 1'b1) n_err++;
   end

   logic [7:0] pl[PL];
   bit         exp_front = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      total++;
      assert (obs === want) else begin
         bad++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, want);
      end
   endtask

   // Called at a negedge; returns at a negedge after `gap` idle cycles.
   task automatic send_byte(input logic [7:0] b, input int gap);
      bv = 1'b1;
      bt = b;
      @(negedge clk);
      bv = 1'b0;
      repeat (gap) @(negedge clk);
   endtask

   function automatic logic [7:0] model_sum();
      int s = 0;
      for (int i = 0; i < PL; i++) s += int'(pl[i]);
      return 8'(s % 256);
   endfunction

   task automatic run_frame(input string tag, input logic [7:0] cs, input int maxgap, input int long_idx);
      int base_w, base_d, base_e, abase;
      bit ok;
      ok     = (cs == model_sum());
      abase  = exp_front ? 0 : PL;
      base_w = wq.size();
      base_d = n_done;
      base_e = n_err;
      send_byte(8'hA5, $urandom_range(0, maxgap));
      send_byte(8'h5A, $urandom_range(0, maxgap));
      for (int i = 0; i < PL; i++)
         send_byte(pl[i], (i == long_idx) ? int'(TMO) - 1 : $urandom_range(0, maxgap));
      send_byte(cs, 0);
      chk({tag, ".done"}, 32'(done), 32'(ok));
      chk({tag, ".err"}, 32'(err), 32'(!ok));
      if (ok) exp_front = ~exp_front;
      chk({tag, ".front"}, 32'(front), 32'(exp_front));
      @(negedge clk);
      chk({tag, ".done_pulse"}, 32'(done), 32'd0);
      chk({tag, ".err_pulse"}, 32'(err), 32'd0);
      chk({tag, ".busy"}, 32'(busy), 32'd0);
      chk({tag, ".nwr"}, 32'(wq.size() - base_w), 32'(PL));
      for (int i = 0; i < PL; i++)
         if (base_w + i < wq.size())
            chk({tag, ".wr"}, 32'(wq[base_w + i]), 32'((abase + i) * 256 + int'(pl[i])));
      chk({tag, ".ndone"}, 32'(n_done - base_d), 32'(ok));
      chk({tag, ".nerr"}, 32'(n_err - base_e), 32'(!ok));
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int base_w, base_e, k;
      rst = 1'b1;
      bv  = 1'b0;
      bt  = 8'h00;
      repeat (3) @(negedge clk);
      chk("rst.wr_en", 32'(wr_en), 32'd0);
      chk("rst.wr_addr", 32'(wr_addr), 32'd0);
      chk("rst.wr_data", 32'(wr_data), 32'd0);
      chk("rst.front", 32'(front), 32'd0);
      chk("rst.done", 32'(done), 32'd0);
      chk("rst.err", 32'(err), 32'd0);
      chk("rst.busy", 32'(busy), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < PL; i++) pl[i] = 8'(i);
      run_frame("seq_good", 8'hE0, 0, -1);
      for (int i = 0; i < PL; i++) pl[i] = 8'hFF;
      run_frame("ff_good", 8'hC0, 2, -1);
      for (int i = 0; i < PL; i++) pl[i] = 8'($urandom);
      run_frame("rand_good", model_sum(), 3, -1);
      for (int i = 0; i < PL; i++) pl[i] = 8'($urandom);
      run_frame("long_gap", model_sum(), 1, 17);

      for (int i = 0; i < PL; i++) pl[i] = 8'(i);
      run_frame("seq_bad", 8'hE1, 1, -1);
      for (int i = 0; i < PL; i++) pl[i] = 8'($urandom);
      run_frame("rand_bad", model_sum() ^ 8'($urandom_range(1, 255)), 2, -1);

      send_byte(8'h12, 0);
      send_byte(8'hA5, 1);
      for (int i = 0; i < PL; i++) pl[i] = 8'($urandom);
      run_frame("resync", model_sum(), 1, -1);

      base_w = wq.size();
      base_e = n_err;
      send_byte(8'h12, 0);
      chk("garb.busy0", 32'(busy), 32'd0);
      send_byte(8'hA5, 0);
      chk("garb.busy1", 32'(busy), 32'd1);
      send_byte(8'h33, 2);
      chk("garb.busy2", 32'(busy), 32'd0);
      chk("garb.nwr", 32'(wq.size() - base_w), 32'd0);
      chk("garb.nerr", 32'(n_err - base_e), 32'd0);

      base_w = wq.size();
      base_e = n_err;
      send_byte(8'hA5, 0);
      send_byte(8'h5A, 0);
      for (int i = 0; i < 10; i++) send_byte(8'($urandom), 0);
      k = 0;
      while (err !== 1'b1 && k < int'(TMO) + 20) begin
         @(negedge clk);
         k++;
      end
      chk("tmo.latency", 32'(k), 32'(TMO));
      chk("tmo.busy", 32'(busy), 32'd0);
      chk("tmo.nwr", 32'(wq.size() - base_w), 32'd10);
      chk("tmo.front", 32'(front), 32'(exp_front));
      @(negedge clk);
      chk("tmo.err_pulse", 32'(err), 32'd0);
      chk("tmo.nerr", 32'(n_err - base_e), 32'd1);
      for (int i = 0; i < PL; i++) pl[i] = 8'($urandom);
      run_frame("after_tmo", model_sum(), 1, -1);

      base_e = n_err;
      send_byte(8'hA5, int'(TMO) + 5);
      chk("hdr_tmo.busy", 32'(busy), 32'd0);
      chk("hdr_tmo.nerr", 32'(n_err - base_e), 32'd0);
      for (int i = 0; i < PL; i++) pl[i] = 8'($urandom);
      run_frame("after_hdr_tmo", model_sum(), 0, -1);

      chk("pre_rst.front", 32'(front), 32'(exp_front));
      send_byte(8'hA5, 0);
      send_byte(8'h5A, 0);
      for (int i = 0; i < 20; i++) send_byte(8'($urandom), 0);
      #2 rst = 1'b1;
      #1;
      chk("arst.wr_en", 32'(wr_en), 32'd0);
      chk("arst.wr_addr", 32'(wr_addr), 32'd0);
      chk("arst.wr_data", 32'(wr_data), 32'd0);
      chk("arst.front", 32'(front), 32'd0);
      chk("arst.busy", 32'(busy), 32'd0);
      chk("arst.done", 32'(done), 32'd0);
      chk("arst.err", 32'(err), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      exp_front = 1'b0;
      @(negedge clk);
      for (int i = 0; i < PL; i++) pl[i] = 8'($urandom);
      run_frame("after_rst", model_sum(), 1, -1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
